c_mem_stage: RTL and testbench

- Memory-access stage of the 32-bit RISC-V pipeline.
- Consumes the ac_* bundle produced by the execute stage:
  - ALU_result is the effective address for loads and stores, and the writeback value for all other instructions.
- Performs byte, half and word loads and stores over a req/ack data-memory handshake and stalls upstream while an access is outstanding.
- Registers the cw_* writeback/bypass bundle that feeds the register file and the execute-stage forwarding muxes.

---
 rtl/c_mem_stage.sv | 219 +++++++++++++++++++++
 tb/tb_c_mem_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_mem_stage.sv
`timescale 1ns/1ps
// c_mem_stage: memory-access stage of the 32-bit RISC-V pipeline.
// Drives a req/ack data-memory handshake for byte/half/word loads and
// stores, stalls upstream while an access is outstanding, and registers
// the cw_* writeback/bypass bundle.
module c_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ac_pc,
  input  logic [4:0]  ac_write_sel,
  input  logic        ac_is_load,
  input  logic        ac_is_store,
  input  logic        ac_is_wb,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ac_store_data,
  input  logic [1:0]  ac_mem_size,
  input  logic        ac_mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] cw_pc,
  output logic [4:0]  cw_write_sel,
  output logic        cw_is_wb,
  output logic [31:0] cw_result,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // The request is held for TIMEOUT+1 cycles in total (the IDLE cycle plus
  // WAIT cycles with cnt = 1..TIMEOUT); the abort cycle is the one after.
  localparam logic [8:0] ABORT_CNT = 9'(TIMEOUT + 1);

  // Select, align and extend the addressed lane of a read word.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   v = {{24{b[7] & ~uns}}, b};
      2'b01:   v = {{16{h[15] & ~uns}}, h};
      default: v = word;
    endcase
    return v;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [8:0]  cnt_r, cnt_nxt_s;
  logic        is_store_s, is_load_s, mem_op_s, misalign_s;
  logic        bad_access_s, access_s;
  logic        req_s, stall_s, abort_s, req_out_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] load_val_s;

  logic [31:0] cw_pc_r, cw_result_r;
  logic [4:0]  cw_write_sel_r;
  logic        cw_is_wb_r, misalign_err_r, bus_err_r;

  // Decode the access type and alignment; store wins if both flags are set.
  always_comb begin
    is_store_s = ac_is_store;
    is_load_s  = ac_is_load & ~ac_is_store;
    mem_op_s   = ac_is_load | ac_is_store;
    case (ac_mem_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = ALU_result[0];
      2'b10:   misalign_s = |ALU_result[1:0];
      default: misalign_s = 1'b1;
    endcase
    bad_access_s = mem_op_s & misalign_s;
    access_s     = mem_op_s & ~misalign_s;
    load_val_s   = load_extract(dmem_rdata, ALU_result[1:0], ac_mem_size,
                                ac_mem_unsigned);
  end

  // Byte enables and lane-replicated store data for the current size.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (ac_mem_size)
      2'b00: begin
        be_s    = 4'b0001 << ALU_result[1:0];
        wdata_s = {4{ac_store_data[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << ALU_result[1:0];
        wdata_s = {2{ac_store_data[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = ac_store_data;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Handshake FSM next-state logic with request, stall and abort decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          req_s = 1'b1;
          if (dmem_ack) begin
            state_nxt_s = ST_IDLE;
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = 9'd1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == ABORT_CNT) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 9'd0;
        end else begin
          req_s = 1'b1;
          if (dmem_ack) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 9'd0;
          end else begin
            stall_s   = 1'b1;
            cnt_nxt_s = cnt_r + 9'd1;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 9'd0;
      end
    endcase
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 9'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Writeback bundle and error pulses; a stall inserts a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cw_pc_r        <= 32'h0000_0000;
      cw_write_sel_r <= 5'd0;
      cw_is_wb_r     <= 1'b0;
      cw_result_r    <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      bus_err_r      <= 1'b0;
    end else begin
      misalign_err_r <= bad_access_s;
      bus_err_r      <= abort_s;
      if (stall_s) begin
        cw_is_wb_r <= 1'b0;
      end else begin
        cw_pc_r        <= ac_pc;
        cw_write_sel_r <= ac_write_sel;
        cw_is_wb_r     <= ac_is_wb & ~is_store_s & ~bad_access_s & ~abort_s;
        cw_result_r    <= is_load_s ? load_val_s : ALU_result;
      end
    end
  end

  // Request-side outputs are combinational; reset forces them low at once.
  assign req_out_s  = req_s & ~reset;
  assign dmem_req   = req_out_s;
  assign dmem_we    = req_out_s & is_store_s;
  assign dmem_addr  = req_out_s ? {ALU_result[31:2], 2'b00} : 32'h0000_0000;
  assign dmem_be    = req_out_s ? be_s : 4'b0000;
  assign dmem_wdata = req_out_s ? wdata_s : 32'h0000_0000;
  assign stall      = stall_s & ~reset;

  assign cw_pc        = cw_pc_r;
  assign cw_write_sel = cw_write_sel_r;
  assign cw_is_wb     = cw_is_wb_r;
  assign cw_result    = cw_result_r;
  assign misalign_err = misalign_err_r;
  assign bus_err      = bus_err_r;

endmodule

// File: tb/tb_c_mem_stage.sv
`timescale 1ns/1ps
// Self-checking bench for c_mem_stage (TIMEOUT = 4): directed vectors with
// literal expectations plus a cycle-by-cycle behavioural model.
module tb_c_mem_stage;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ac_pc = 32'h0;
  logic [4:0]  ac_write_sel = 5'd0;
  logic        ac_is_load = 1'b0, ac_is_store = 1'b0, ac_is_wb = 1'b0;
  logic [31:0] ALU_result = 32'h0, ac_store_data = 32'h0;
  logic [1:0]  ac_mem_size = 2'b00;
  logic        ac_mem_unsigned = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
  logic [3:0]  dmem_be;
  logic        stall, cw_is_wb, misalign_err, bus_err;
  logic [31:0] cw_pc, cw_result;
  logic [4:0]  cw_write_sel;

  int checks = 0;
  int errors = 0;

  c_mem_stage #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ac_pc(ac_pc), .ac_write_sel(ac_write_sel),
    .ac_is_load(ac_is_load), .ac_is_store(ac_is_store), .ac_is_wb(ac_is_wb),
    .ALU_result(ALU_result), .ac_store_data(ac_store_data),
    .ac_mem_size(ac_mem_size), .ac_mem_unsigned(ac_mem_unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .cw_pc(cw_pc),
    .cw_write_sel(cw_write_sel), .cw_is_wb(cw_is_wb), .cw_result(cw_result),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          age = 0;            // cycles the current access has already requested
  logic [31:0] m_pc = 32'h0, m_res = 32'h0;
  logic [4:0]  m_sel = 5'd0;
  logic        m_wb = 1'b0, m_mis = 1'b0, m_bus = 1'b0;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * a)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * a[1])) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  initial begin
    logic        is_st, is_ld, memop, bad, acc, e_req, e_abort, e_stall;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    forever begin
      @(negedge clock);
      is_st = ac_is_store;
      is_ld = ac_is_load && !ac_is_store;
      memop = ac_is_load || ac_is_store;
      bad   = memop && (ac_mem_size == 2'd3 ||
                        (ac_mem_size == 2'd1 && ALU_result[0]) ||
                        (ac_mem_size == 2'd2 && ALU_result[1:0] != 2'd0));
      acc     = memop && !bad;
      e_req   = acc && (age <= TMO) && !reset;
      e_abort = acc && (age > TMO);
      e_stall = e_req && !dmem_ack;
      e_be = 4'h0;
      e_wd = 32'h0;
      if (e_req) begin
        case (ac_mem_size)
          2'd0: begin e_be = 4'(1 << ALU_result[1:0]); e_wd = ac_store_data[7:0] * 32'h0101_0101; end
          2'd1: begin e_be = 4'(3 << ALU_result[1:0]); e_wd = ac_store_data[15:0] * 32'h0001_0001; end
          default: begin e_be = 4'hF; e_wd = ac_store_data; end
        endcase
      end
      check("dmem_req", 32'(dmem_req), 32'(e_req));
      check("stall", 32'(stall), 32'(e_stall));
      check("dmem_we", 32'(dmem_we), 32'(e_req && is_st));
      check("dmem_be", 32'(dmem_be), 32'(e_be));
      check("dmem_wdata", dmem_wdata, e_wd);
      if (e_req) check("dmem_addr", dmem_addr, ALU_result & 32'hFFFF_FFFC);
      if (reset) begin
        check("cw_pc_rst", cw_pc, 32'h0);
        check("cw_is_wb_rst", 32'(cw_is_wb), 32'h0);
        check("cw_result_rst", cw_result, 32'h0);
      end else begin
        check("cw_pc", cw_pc, m_pc);
        check("cw_write_sel", 32'(cw_write_sel), 32'(m_sel));
        check("cw_is_wb", 32'(cw_is_wb), 32'(m_wb));
        check("cw_result", cw_result, m_res);
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
        check("bus_err", 32'(bus_err), 32'(m_bus));
      end
      @(posedge clock);
      if (reset) begin
        age = 0; m_pc = 32'h0; m_res = 32'h0; m_sel = 5'd0;
        m_wb = 1'b0; m_mis = 1'b0; m_bus = 1'b0;
      end else begin
        m_mis = bad;
        m_bus = e_abort;
        if (e_stall) begin
          age++;
          m_wb = 1'b0;
        end else begin
          age   = 0;
          m_pc  = ac_pc;
          m_sel = ac_write_sel;
          m_wb  = ac_is_wb && !is_st && !bad && !e_abort;
          m_res = is_ld ? extract(dmem_rdata, ALU_result[1:0], ac_mem_size, ac_mem_unsigned)
                        : ALU_result;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
    ac_mem_size = 2'b00; ac_mem_unsigned = 1'b0; dmem_ack = 1'b0;
    ALU_result = 32'h0; ac_store_data = 32'h0; ac_write_sel = 5'd0;
  endtask

  task automatic set_mem(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] pc);
    ac_is_load = ld; ac_is_store = st; ac_mem_size = sz;
    ALU_result = addr; ac_pc = pc; ac_is_wb = 1'b1; ac_write_sel = 5'd9;
  endtask

  initial begin
    int n;
    step(); step();
    check("rst_cw_result", cw_result, 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    reset = 1'b0;
    step();

    // ALU pass-through
    ac_pc = 32'h0000_0040; ALU_result = 32'h0000_1234; ac_is_wb = 1'b1; ac_write_sel = 5'd5;
    #1 check("alu_no_req", 32'(dmem_req), 32'h0);
    step();
    check("alu_result", cw_result, 32'h0000_1234);
    check("alu_sel", 32'(cw_write_sel), 32'd5);
    check("alu_wb", 32'(cw_is_wb), 32'h1);

    // Zero-wait LB then LBU
    set_mem(1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h44);
    dmem_rdata = 32'h80FF_0000; dmem_ack = 1'b1;
    #1 check("lb_be", 32'(dmem_be), 32'h8);
    check("lb_stall", 32'(stall), 32'h0);
    check("lb_addr", dmem_addr, 32'h0000_0100);
    step();
    check("lb_result", cw_result, 32'hFFFF_FF80);
    check("lb_wb", 32'(cw_is_wb), 32'h1);
    ac_mem_unsigned = 1'b1;
    step();
    check("lbu_result", cw_result, 32'h0000_0080);
    idle_in();
    step();

    // SH with ack after 3 stall cycles
    set_mem(1'b0, 1'b1, 2'b01, 32'h0000_0202, 32'h48);
    ac_store_data = 32'hABCD_1234;
    #1 check("sh_addr", dmem_addr, 32'h0000_0200);
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_we", 32'(dmem_we), 32'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      step();
      check("sh_wb_bubble", 32'(cw_is_wb), 32'h0);
    end
    check("sh_stall_cycles", n, 32'd3);
    dmem_ack = 1'b1;
    #1 check("sh_ack_stall", 32'(stall), 32'h0);
    step();
    check("sh_wb_after", 32'(cw_is_wb), 32'h0);
    idle_in();
    step();

    // Misaligned LW and reserved size
    set_mem(1'b1, 1'b0, 2'b10, 32'h0000_0302, 32'h4C);
    #1 check("mis_req", 32'(dmem_req), 32'h0);
    step();
    check("mis_err", 32'(misalign_err), 32'h1);
    check("mis_wb", 32'(cw_is_wb), 32'h0);
    idle_in();
    step();
    check("mis_err_pulse", 32'(misalign_err), 32'h0);
    set_mem(1'b1, 1'b0, 2'b11, 32'h0000_0300, 32'h50);
    step();
    check("rsv_err", 32'(misalign_err), 32'h1);
    check("rsv_wb", 32'(cw_is_wb), 32'h0);
    idle_in();
    step();

    // Timeout abort
    set_mem(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h54);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!dmem_req) break;
      check("tmo_stall_follows", 32'(stall), 32'h1);
      n++;
      step();
    end
    check("tmo_req_cycles", n, 32'd5);
    check("tmo_stall_drop", 32'(stall), 32'h0);
    step();
    check("tmo_bus_err", 32'(bus_err), 32'h1);
    check("tmo_wb", 32'(cw_is_wb), 32'h0);
    idle_in();
    step();
    check("tmo_bus_pulse", 32'(bus_err), 32'h0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("late_ack_wb", 32'(cw_is_wb), 32'h0);
    step();

    // Reset in the middle of a wait
    set_mem(1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h58);
    step(); step();
    #1 reset = 1'b1;
    #1 check("mid_rst_req", 32'(dmem_req), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_pc", cw_pc, 32'h0);
    idle_in();
    step();
    reset = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("stray_ack_wb", 32'(cw_is_wb), 32'h0);
    set_mem(1'b1, 1'b0, 2'b01, 32'h0000_0602, 32'h5C);
    ac_mem_unsigned = 1'b0; dmem_rdata = 32'h8001_7FFF; dmem_ack = 1'b1;
    #1 check("post_rst_stall", 32'(stall), 32'h0);
    step();
    check("post_rst_lh", cw_result, 32'hFFFF_8001);
    idle_in();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
